// File: rtl/pixel_stream_source_pkg.sv
// Shared constants and FSM state type for the pixel stream source.
package pixel_stream_source_pkg;

    localparam int unsigned WORD_BITS       = 8;
    localparam int unsigned BYTES_PER_PIXEL = 3;
    localparam int unsigned PIXEL_BITS      = WORD_BITS * BYTES_PER_PIXEL;

    typedef enum logic [2:0] {
        StIdle,
        StF0,
        StF1,
        StF2,
        StF3,
        StEmit,
        StDone
    } state_e;

endpackage

// File: rtl/pixel_stream_source_raster_counter.sv
// Column/row position within the frame; advances once per accepted pixel.
module pixel_stream_source_raster_counter
    import pixel_stream_source_pkg::*;
#(
    parameter int unsigned DIM_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             advance,
    input  logic [DIM_W-1:0] width,
    input  logic [DIM_W-1:0] height,
    output logic             first_col,
    output logic             first_pix,
    output logic             last_pix
);

    logic [DIM_W-1:0] col_q;
    logic [DIM_W-1:0] row_q;
    logic             last_col;

    assign last_col  = (col_q == width - DIM_W'(1));
    assign first_col = (col_q == '0);
    assign first_pix = first_col && (row_q == '0);
    assign last_pix  = last_col && (row_q == height - DIM_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q <= '0;
            row_q <= '0;
        end else if (clear) begin
            col_q <= '0;
            row_q <= '0;
        end else if (advance) begin
            if (last_col) begin
                col_q <= '0;
                row_q <= row_q + DIM_W'(1);
            end else begin
                col_q <= col_q + DIM_W'(1);
            end
        end
    end

endmodule

// File: rtl/pixel_stream_source.sv
// Streams a packed 24-bit frame from byte-wide synchronous memory, one pixel per 3 reads,
// with downstream ready back-pressure.
module pixel_stream_source
    import pixel_stream_source_pkg::*;
#(
    parameter int unsigned ADDR_W  = 20,
    parameter int unsigned DIM_W   = 16,
    parameter int unsigned PIXEL_W = PIXEL_BITS
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [DIM_W-1:0]     width,
    input  logic [DIM_W-1:0]     height,
    input  logic [ADDR_W-1:0]    base_addr,
    output logic                 mem_rd,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [WORD_BITS-1:0] mem_rdata,
    output logic [PIXEL_W-1:0]   data,
    output logic                 en,
    output logic                 hsync,
    output logic                 vsync,
    input  logic                 ready,
    output logic                 busy,
    output logic                 frame_done
);

    state_e state_q, state_d;

    logic [ADDR_W-1:0]    ptr_q, ptr_d;
    logic [DIM_W-1:0]     width_q, height_q;
    logic [WORD_BITS-1:0] b0_q, b1_q;
    logic [PIXEL_W-1:0]   data_q;
    logic                 en_q, hsync_q, vsync_q, mem_rd_q, busy_q, done_q;
    logic                 en_d, hsync_d, vsync_d, mem_rd_d, busy_d, done_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;

    logic start_ok, accept, zero_dim;
    logic first_col, first_pix, last_pix;

    assign start_ok = (state_q == StIdle) && start;
    assign accept   = (state_q == StEmit) && ready;
    assign zero_dim = (width == '0) || (height == '0);

    pixel_stream_source_raster_counter #(
        .DIM_W(DIM_W)
    ) u_raster (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (start_ok),
        .advance  (accept),
        .width    (width_q),
        .height   (height_q),
        .first_col(first_col),
        .first_pix(first_pix),
        .last_pix (last_pix)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = zero_dim ? StDone : StF0;
            StF0:    state_d = StF1;
            StF1:    state_d = StF2;
            StF2:    state_d = StF3;
            StF3:    state_d = StEmit;
            StEmit:  if (ready) state_d = last_pix ? StDone : StF0;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        if (start_ok) begin
            ptr_d = base_addr;
        end else if (accept) begin
            ptr_d = ptr_q + ADDR_W'(BYTES_PER_PIXEL);
        end
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_comb begin
        mem_rd_d   = 1'b0;
        mem_addr_d = '0;
        unique case (state_d)
            StF0: begin
                mem_rd_d   = 1'b1;
                mem_addr_d = ptr_d;
            end
            StF1: begin
                mem_rd_d   = 1'b1;
                mem_addr_d = ptr_d + ADDR_W'(1);
            end
            StF2: begin
                mem_rd_d   = 1'b1;
                mem_addr_d = ptr_d + ADDR_W'(2);
            end
            default: ;
        endcase
        en_d    = (state_d == StEmit);
        hsync_d = en_d && first_col;
        vsync_d = en_d && first_pix;
        busy_d  = (state_d != StIdle);
        done_d  = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q      <= '0;
            width_q    <= '0;
            height_q   <= '0;
            b0_q       <= '0;
            b1_q       <= '0;
            data_q     <= '0;
            en_q       <= 1'b0;
            hsync_q    <= 1'b0;
            vsync_q    <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            if (start_ok) begin
                width_q  <= width;
                height_q <= height;
            end
            // Read data arrives one cycle after its strobe, so each byte lands a state later.
            if (state_q == StF1) b0_q <= mem_rdata;
            if (state_q == StF2) b1_q <= mem_rdata;
            if (state_q == StF3) data_q <= {mem_rdata, b1_q, b0_q};
            en_q       <= en_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign mem_rd     = mem_rd_q;
    assign mem_addr   = mem_addr_q;
    assign data       = data_q;
    assign en         = en_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule
